// File: rtl/flex_cnt_pkg.sv
// Shared types and defaults for the flex counter family.
package flex_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } cnt_state_t;

    localparam int unsigned FLEX_CNT_DEFAULT_BITS = 4;

endpackage

// File: rtl/flex_down_counter.sv
// Loadable down-counter / countdown timer with registered zero flag and optional auto-reload.
// Define FLEX_DOWN_CNT_ERR_EN to add the sticky underflow_err output.
module flex_down_counter
    import flex_cnt_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS = FLEX_CNT_DEFAULT_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    auto_reload,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    zero_flag,
`ifdef FLEX_DOWN_CNT_ERR_EN
    output logic                    underflow_err,
`endif
    output logic                    busy
);

    localparam logic [NUM_CNT_BITS-1:0] CntZero = '0;
    localparam logic [NUM_CNT_BITS-1:0] CntOne  = NUM_CNT_BITS'(1);

    cnt_state_t              state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
    logic                    err_q, err_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        err_d    = err_q;
        if (clear) begin
            state_d = IDLE;
            count_d = CntZero;
            err_d   = 1'b0;
        end else if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            err_d    = 1'b0;
            state_d  = (load_val != CntZero) ? RUN : EXPIRED;
        end else if (count_enable) begin
            unique case (state_q)
                RUN: begin
                    count_d = count_q - CntOne;
                    if (count_q == CntOne) begin
                        state_d = EXPIRED;
                    end
                end
                EXPIRED: begin
                    // Count sits at zero here; only a non-zero reload leaves EXPIRED.
                    if (auto_reload && (reload_q != CntZero)) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= CntZero;
            reload_q <= CntZero;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            err_q    <= err_d;
        end
    end

    assign count_out = count_q;
    assign zero_flag = (state_q == EXPIRED);
    assign busy      = (state_q == RUN);

`ifdef FLEX_DOWN_CNT_ERR_EN
    assign underflow_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_flex_down_counter.sv
// Scoreboard bench for flex_down_counter: directed plan sequences plus randomized traffic.
module tb_flex_down_counter;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         count_enable = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] count_out;
    logic         zero_flag;
    logic         busy;
`ifdef FLEX_DOWN_CNT_ERR_EN
    logic         underflow_err;
`endif

    flex_down_counter #(.NUM_CNT_BITS(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .auto_reload  (auto_reload),
        .count_out    (count_out),
        .zero_flag    (zero_flag),
`ifdef FLEX_DOWN_CNT_ERR_EN
        .underflow_err(underflow_err),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit zero;
        bit busy;
        bit err;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference: "active" means a loaded countdown exists; state follows from count.
    int m_count  = 0;
    int m_reload = 0;
    bit m_active = 0;
    bit m_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step(input bit r, input bit c, input bit l, input int lv,
                        input bit e, input bit a);
        exp_t x;
        @(negedge clk);
        rst = r; clear = c; load = l; load_val = W'(lv); count_enable = e; auto_reload = a;
        if (r) begin
            m_count = 0; m_reload = 0; m_active = 0; m_err = 0;
        end else if (c) begin
            m_count = 0; m_active = 0; m_err = 0;
        end else if (l) begin
            m_count = lv; m_reload = lv; m_active = 1; m_err = 0;
        end else if (e && m_active) begin
            if (m_count > 0) m_count = m_count - 1;
            else if (a && m_reload != 0) m_count = m_reload;
            else m_err = 1;
        end
        x.count = m_count;
        x.zero  = m_active && (m_count == 0);
        x.busy  = m_active && (m_count != 0);
        x.err   = m_err;
        @(posedge clk);
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("count_out", int'(count_out), x.count);
                chk("zero_flag", int'(zero_flag), int'(x.zero));
                chk("busy", int'(busy), int'(x.busy));
`ifdef FLEX_DOWN_CNT_ERR_EN
                chk("underflow_err", int'(underflow_err), int'(x.err));
`endif
            end
        end
    end

    initial begin : stim
        // rst, then load 3 counting down to a held zero
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 1, 0);
        repeat (6) step(0, 0, 0, 0, 1, 0);
        // periodic mode with reload 2
        step(0, 0, 1, 2, 1, 1);
        repeat (7) step(0, 0, 0, 0, 1, 1);
        // load 0 goes straight to EXPIRED; reload 0 never restarts
        step(0, 0, 1, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 1, 1);
        // clear beats load; IDLE ignores enable
        step(0, 1, 1, 9, 1, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        // reload mid-count, then pause
        step(0, 0, 1, 7, 0, 0);
        repeat (2) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 15, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        // reset from RUN at count 6
        step(0, 0, 1, 8, 0, 0);
        repeat (2) step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 1, 1);
        // max value boundary
        step(0, 0, 1, 15, 1, 1);
        repeat (18) step(0, 0, 0, 0, 1, 1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1));
        end
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
